// File: rtl/enc_lookup_tracker_if.sv
// Handshake bundle between the hash-encoding engine and the lookup tracker.
// master = engine side, slave = tracker side.
interface enc_lookup_tracker_if #(
    parameter int TABLE_COL = 128,
    parameter int NUM_ROWS  = 4,
    parameter int CNT_WIDTH = 16
);
    localparam int ID_W = $clog2(NUM_ROWS);

    logic                 alloc_valid;
    logic [CNT_WIDTH-1:0] alloc_cnt;
    logic                 alloc_ready;
    logic [ID_W-1:0]      alloc_id;

    logic                 sent_valid;
    logic [ID_W-1:0]      sent_id;
    logic [TABLE_COL-1:0] sent_mask;

    logic                 ret_valid;
    logic [ID_W-1:0]      ret_id;
    logic [CNT_WIDTH-1:0] ret_num;

    logic                 done_valid;
    logic                 done_ready;
    logic [ID_W-1:0]      done_id;
    logic [TABLE_COL-1:0] done_sent;

    logic                 err;

    modport master (
        output alloc_valid, alloc_cnt,
        input  alloc_ready, alloc_id,
        output sent_valid, sent_id, sent_mask,
        output ret_valid, ret_id, ret_num,
        input  done_valid, done_id, done_sent,
        output done_ready,
        input  err
    );

    modport slave (
        input  alloc_valid, alloc_cnt,
        output alloc_ready, alloc_id,
        input  sent_valid, sent_id, sent_mask,
        input  ret_valid, ret_id, ret_num,
        output done_valid, done_id, done_sent,
        input  done_ready,
        output err
    );
endinterface

// File: rtl/enc_lookup_tracker.sv
// Outstanding-lookup tracker: per-row sent-column bitmap and remaining-return
// down-counter, rows retired strictly in allocation order.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ROW_FREE   | slot unused; sent/ret aimed here are protocol errors
// ROW_ACTIVE | allocated, feature returns still outstanding
// ROW_DONE   | all returns in; waits to become head and be retired
module enc_lookup_tracker #(
    parameter int TABLE_COL = 128,
    parameter int NUM_ROWS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    enc_lookup_tracker_if.slave bus
);
    localparam int ID_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        ROW_FREE   = 2'd0,
        ROW_ACTIVE = 2'd1,
        ROW_DONE   = 2'd2
    } row_state_t;

    row_state_t           r_state  [NUM_ROWS];
    logic [TABLE_COL-1:0] r_bitmap [NUM_ROWS];
    logic [CNT_WIDTH-1:0] r_remain [NUM_ROWS];
    logic [ID_W-1:0]      r_head;
    logic [ID_W-1:0]      r_tail;
    logic [ID_W:0]        r_occ;
    logic                 r_err;

    logic                 w_alloc_ready;
    logic                 w_alloc_fire;
    logic                 w_head_done;
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] w_ret_remain;
    logic [CNT_WIDTH-1:0] w_ret_diff;

    // Readiness depends only on registered occupancy, so a same-cycle retire
    // never opens a slot for a same-cycle alloc.
    assign w_alloc_ready = (r_occ != (ID_W+1)'(NUM_ROWS));
    assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
    assign w_head_done   = (r_state[r_head] == ROW_DONE);
    assign w_retire      = w_head_done && bus.done_ready;
    assign w_ret_remain  = r_remain[bus.ret_id];
    assign w_ret_diff    = w_ret_remain - bus.ret_num;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_state[i]  <= ROW_FREE;
                r_bitmap[i] <= '0;
                r_remain[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (bus.sent_valid) begin
                if (r_state[bus.sent_id] == ROW_ACTIVE) begin
                    r_bitmap[bus.sent_id] <= r_bitmap[bus.sent_id] | bus.sent_mask;
                end else begin
                    r_err <= 1'b1;
                end
            end

            if (bus.ret_valid) begin
                if (r_state[bus.ret_id] == ROW_ACTIVE) begin
                    if (bus.ret_num > w_ret_remain) begin
                        // Over-return: saturate at zero and close the row.
                        r_remain[bus.ret_id] <= '0;
                        r_state[bus.ret_id]  <= ROW_DONE;
                        r_err                <= 1'b1;
                    end else begin
                        r_remain[bus.ret_id] <= w_ret_diff;
                        if (w_ret_diff == '0) begin
                            r_state[bus.ret_id] <= ROW_DONE;
                        end
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end

            if (w_retire) begin
                r_state[r_head]  <= ROW_FREE;
                r_bitmap[r_head] <= '0;
                r_head           <= r_head + ID_W'(1);
            end

            // The tail slot is always FREE when an alloc fires, so this write
            // never collides with a legal sent/ret/retire on another row.
            if (w_alloc_fire) begin
                r_state[r_tail]  <= (bus.alloc_cnt == '0) ? ROW_DONE : ROW_ACTIVE;
                r_remain[r_tail] <= bus.alloc_cnt;
                r_bitmap[r_tail] <= '0;
                r_tail           <= r_tail + ID_W'(1);
            end

            r_occ <= r_occ + (ID_W+1)'(w_alloc_fire) - (ID_W+1)'(w_retire);
        end
    end

    assign bus.alloc_ready = w_alloc_ready;
    assign bus.alloc_id    = r_tail;
    assign bus.done_valid  = w_head_done;
    assign bus.done_id     = r_head;
    assign bus.done_sent   = r_bitmap[r_head];
    assign bus.err         = r_err;
endmodule

// File: tb/tb_enc_lookup_tracker.sv
// Directed bench for enc_lookup_tracker: ordering, bitmap accumulation,
// error flag behaviour, stall stability and reset/wrap.
module tb_enc_lookup_tracker;
    localparam int TABLE_COL = 128;
    localparam int NUM_ROWS  = 4;
    localparam int CNT_WIDTH = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    enc_lookup_tracker_if #(
        .TABLE_COL(TABLE_COL), .NUM_ROWS(NUM_ROWS), .CNT_WIDTH(CNT_WIDTH)
    ) u_if ();

    enc_lookup_tracker #(
        .TABLE_COL(TABLE_COL), .NUM_ROWS(NUM_ROWS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        u_if.alloc_valid = 1'b0;
        u_if.sent_valid  = 1'b0;
        u_if.ret_valid   = 1'b0;
        u_if.done_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (u_if.alloc_ready !== 1'b1 || u_if.alloc_id !== 2'd0 || u_if.done_valid !== 1'b0 ||
            u_if.done_id !== 2'd0 || u_if.done_sent !== '0 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values got rdy=%0b id=%0d dv=%0b did=%0d ds=%h err=%0b want 1 0 0 0 0 0",
                     u_if.alloc_ready, u_if.alloc_id, u_if.done_valid, u_if.done_id, u_if.done_sent, u_if.err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd3;
        step();
        n_checks++;
        if (u_if.alloc_id !== 2'd1) begin
            n_errors++; $display("FAIL basic_tail got %0d want 1", u_if.alloc_id);
        end
        u_if.sent_valid = 1'b1; u_if.sent_id = 2'd0; u_if.sent_mask = 128'h5;
        step();
        u_if.sent_valid = 1'b1; u_if.sent_id = 2'd0; u_if.sent_mask = 128'hA;
        step();
        u_if.ret_valid = 1'b1; u_if.ret_id = 2'd0; u_if.ret_num = 16'd1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b0) begin
            n_errors++; $display("FAIL basic_not_done got %0b want 0", u_if.done_valid);
        end
        u_if.ret_valid = 1'b1; u_if.ret_id = 2'd0; u_if.ret_num = 16'd2;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_sent !== 128'hF || u_if.done_id !== 2'd0 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done got dv=%0b ds=%h id=%0d err=%0b want 1 f 0 0",
                     u_if.done_valid, u_if.done_sent, u_if.done_id, u_if.err);
        end
        u_if.done_ready = 1'b1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b0 || u_if.done_sent !== '0) begin
            n_errors++; $display("FAIL basic_retire got dv=%0b ds=%h want 0 0", u_if.done_valid, u_if.done_sent);
        end
    endtask

    task automatic test_order();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (u_if.alloc_id !== 2'(i) || u_if.alloc_ready !== 1'b1) begin
                n_errors++; $display("FAIL order_alloc%0d got id=%0d rdy=%0b want %0d 1", i, u_if.alloc_id, u_if.alloc_ready, i);
            end
            u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd1;
            step();
        end
        n_checks++;
        if (u_if.alloc_ready !== 1'b0) begin
            n_errors++; $display("FAIL order_full got %0b want 0", u_if.alloc_ready);
        end
        u_if.ret_valid = 1'b1; u_if.ret_id = 2'd2; u_if.ret_num = 16'd1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b0) begin
            n_errors++; $display("FAIL order_row2_waits got %0b want 0", u_if.done_valid);
        end
        u_if.ret_valid = 1'b1; u_if.ret_id = 2'd0; u_if.ret_num = 16'd1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_id !== 2'd0) begin
            n_errors++; $display("FAIL order_head0 got dv=%0b id=%0d want 1 0", u_if.done_valid, u_if.done_id);
        end
        // Alloc offered alongside the retire must not fire while full.
        u_if.done_ready = 1'b1; u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd1;
        step();
        n_checks++;
        if (u_if.alloc_ready !== 1'b1 || u_if.alloc_id !== 2'd0 || u_if.done_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL order_after_retire got rdy=%0b id=%0d dv=%0b want 1 0 0", u_if.alloc_ready, u_if.alloc_id, u_if.done_valid);
        end
        u_if.ret_valid = 1'b1; u_if.ret_id = 2'd1; u_if.ret_num = 16'd1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_id !== 2'd1) begin
            n_errors++; $display("FAIL order_head1 got dv=%0b id=%0d want 1 1", u_if.done_valid, u_if.done_id);
        end
        u_if.done_ready = 1'b1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_id !== 2'd2) begin
            n_errors++; $display("FAIL order_head2 got dv=%0b id=%0d want 1 2", u_if.done_valid, u_if.done_id);
        end
        u_if.done_ready = 1'b1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b0 || u_if.done_id !== 2'd3 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL order_head3 got dv=%0b id=%0d err=%0b want 0 3 0", u_if.done_valid, u_if.done_id, u_if.err);
        end
    endtask

    task automatic test_zero_cnt();
        do_reset();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd0;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_sent !== '0 || u_if.done_id !== 2'd0 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_cnt got dv=%0b ds=%h id=%0d err=%0b want 1 0 0 0",
                     u_if.done_valid, u_if.done_sent, u_if.done_id, u_if.err);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd2;
        step();
        u_if.ret_valid = 1'b1; u_if.ret_id = 2'd0; u_if.ret_num = 16'd5;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.err !== 1'b1) begin
            n_errors++; $display("FAIL overflow got dv=%0b err=%0b want 1 1", u_if.done_valid, u_if.err);
        end
        u_if.done_ready = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (u_if.err !== 1'b1 || u_if.done_valid !== 1'b0) begin
            n_errors++; $display("FAIL overflow_sticky got err=%0b dv=%0b want 1 0", u_if.err, u_if.done_valid);
        end
        do_reset();
        n_checks++;
        if (u_if.err !== 1'b0) begin
            n_errors++; $display("FAIL overflow_rst_clear got %0b want 0", u_if.err);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd4;
        step();
        u_if.sent_valid = 1'b1; u_if.sent_id = 2'd0; u_if.sent_mask = 128'h30;
        step();
        u_if.sent_valid = 1'b1; u_if.sent_id = 2'd0; u_if.sent_mask = 128'h1;
        u_if.ret_valid  = 1'b1; u_if.ret_id  = 2'd0; u_if.ret_num   = 16'd4;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_sent !== 128'h31 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL same_cycle got dv=%0b ds=%h err=%0b want 1 31 0", u_if.done_valid, u_if.done_sent, u_if.err);
        end
        u_if.sent_valid = 1'b1; u_if.sent_id = 2'd2; u_if.sent_mask = 128'hFF;
        step();
        n_checks++;
        if (u_if.err !== 1'b1 || u_if.done_sent !== 128'h31) begin
            n_errors++; $display("FAIL sent_free got err=%0b ds=%h want 1 31", u_if.err, u_if.done_sent);
        end
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd0;
        step();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd0;
        step();
        u_if.done_ready = 1'b1;
        step();
        u_if.done_ready = 1'b1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_id !== 2'd2 || u_if.done_sent !== '0) begin
            n_errors++;
            $display("FAIL sent_free_bitmap got dv=%0b id=%0d ds=%h want 1 2 0", u_if.done_valid, u_if.done_id, u_if.done_sent);
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd1;
        step();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd2;
        step();
        u_if.ret_valid = 1'b1; u_if.ret_id = 2'd0; u_if.ret_num = 16'd1;
        step();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd1;
        u_if.sent_valid  = 1'b1; u_if.sent_id   = 2'd1; u_if.sent_mask = 128'h4;
        u_if.ret_valid   = 1'b1; u_if.ret_id    = 2'd1; u_if.ret_num   = 16'd2;
        u_if.done_ready  = 1'b1;
        step();
        n_checks++;
        if (u_if.done_valid !== 1'b1 || u_if.done_id !== 2'd1 || u_if.done_sent !== 128'h4 ||
            u_if.alloc_id !== 2'd3 || u_if.alloc_ready !== 1'b1 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL concurrent got dv=%0b did=%0d ds=%h aid=%0d rdy=%0b err=%0b want 1 1 4 3 1 0",
                     u_if.done_valid, u_if.done_id, u_if.done_sent, u_if.alloc_id, u_if.alloc_ready, u_if.err);
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd1;
        step();
        u_if.sent_valid = 1'b1; u_if.sent_id = 2'd0; u_if.sent_mask = 128'hC3;
        u_if.ret_valid  = 1'b1; u_if.ret_id  = 2'd0; u_if.ret_num   = 16'd1;
        u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd5;
        step();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (u_if.done_valid !== 1'b1 || u_if.done_id !== 2'd0 || u_if.done_sent !== 128'hC3) begin
                n_errors++;
                $display("FAIL stall_c%0d got dv=%0b id=%0d ds=%h want 1 0 c3", c, u_if.done_valid, u_if.done_id, u_if.done_sent);
            end
            step();
        end
        rst = 1'b1; u_if.done_ready = 1'b1; u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd1;
        step();
        rst = 1'b0;
        n_checks++;
        if (u_if.alloc_ready !== 1'b1 || u_if.alloc_id !== 2'd0 || u_if.done_valid !== 1'b0 ||
            u_if.done_id !== 2'd0 || u_if.done_sent !== '0 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL midflight_rst got rdy=%0b id=%0d dv=%0b did=%0d ds=%h err=%0b want 1 0 0 0 0 0",
                     u_if.alloc_ready, u_if.alloc_id, u_if.done_valid, u_if.done_id, u_if.done_sent, u_if.err);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (u_if.alloc_id !== 2'(i % 4) || u_if.alloc_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL wrap_alloc%0d got id=%0d rdy=%0b want %0d 1", i, u_if.alloc_id, u_if.alloc_ready, i % 4);
            end
            u_if.alloc_valid = 1'b1; u_if.alloc_cnt = 16'd0; u_if.done_ready = 1'b1;
            step();
        end
        n_checks++;
        if (u_if.done_id !== 2'd3 || u_if.done_valid !== 1'b1 || u_if.err !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_head got id=%0d dv=%0b err=%0b want 3 1 0", u_if.done_id, u_if.done_valid, u_if.err);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        u_if.alloc_valid = 1'b0; u_if.alloc_cnt = '0;
        u_if.sent_valid  = 1'b0; u_if.sent_id   = '0; u_if.sent_mask = '0;
        u_if.ret_valid   = 1'b0; u_if.ret_id    = '0; u_if.ret_num   = '0;
        u_if.done_ready  = 1'b0;
        test_reset();
        test_basic();
        test_order();
        test_zero_cnt();
        test_overflow();
        test_same_cycle();
        test_concurrent();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
